mux_n1_pipe: RTL and testbench
==============================

// Module: mux_n1_pipe
// PURPOSE
//  Parametrised N:1 datapath mux with a registered, flow-controlled output for the pipeline processor.
//  Replaces fixed 4:1 selects on stage boundaries (forwarding, writeback source) where a pipeline register follows.
//  Select and pipeline register are fused; a 2-entry skid buffer gives full throughput with no combinational READY path.
//  Supports stall via OUT_READY and a synchronous flush for branch/exception squash.
// PARAMETERS
//  size   32   data width of each input and of OUT
//  N_IN   4    number of data inputs; legal range 2..16
//  SEL_W  $clog2(N_IN)   select width; derived, never overridden
// PORTS
//  CLK        in   1           rising-edge clock
//  RST        in   1           asynchronous, active-high reset
//  IN         in   N_IN*size   flattened inputs; input k = IN[k*size +: size]
//  SEL        in   SEL_W       binary select, sampled with IN_VALID
//  IN_VALID   in   1           upstream word valid
//  IN_READY   out  1           block can accept; depends only on registered state
//  FLUSH      in   1           synchronous squash of all held words
//  OUT        out  size        selected word at head of buffer
//  OUT_SEL    out  SEL_W       SEL value captured with OUT
//  SEL_ERR    out  1           OUT word came from an out-of-range SEL
//  OUT_VALID  out  1           OUT/OUT_SEL/SEL_ERR are valid
//  OUT_READY  in   1           downstream accepts; low = stall
// BEHAVIOUR
//  - Reset (async, RST=1): OUT=0, OUT_SEL=0, SEL_ERR=0, OUT_VALID=0, skid empty, IN_READY=1.
//  - Accept: IN_VALID & IN_READY at edge. Drain: OUT_VALID & OUT_READY at edge.
//  - Latency: 1 cycle; word accepted at edge t is on OUT after edge t if buffer was empty.
//  - States: EMPTY (no word), ONE (head valid), FULL (head + skid valid).
//      EMPTY: accept -> ONE (head <= mux(IN,SEL)).
//      ONE:   accept & drain -> ONE (head replaced); accept only -> FULL (skid loaded);
//             drain only -> EMPTY; neither -> ONE (head held).
//      FULL:  drain -> ONE (head <= skid); no drain -> FULL; IN_READY=0, no accept.
//  - IN_READY = (state != FULL); derived from registers only.
//  - Throughput: 1 word/cycle while OUT_READY=1; stall of any length loses no word, duplicates none.
//  - Order: strictly FIFO; skid word never bypasses head.
//  - Select: SEL < N_IN -> word = input SEL. SEL >= N_IN (only when N_IN not power of 2)
//    -> word = 0, SEL_ERR=1 travels with that word; otherwise SEL_ERR=0.
//  - OUT/OUT_SEL/SEL_ERR are held stable while OUT_VALID=1 & OUT_READY=0.
//  - FLUSH=1 at edge: state -> EMPTY, IN_READY=1 next cycle; takes priority over same-cycle
//    accept and drain (accepted word is discarded); data registers not cleared.
//  - RST during any state: immediate return to reset values; words in flight lost.
//  - No width arithmetic; OUT is an exact copy of the selected size-bit input.
// STRUCTURE
//  - Package mux_pkg: typedef enum {EMPTY, ONE, FULL} skid_state_t; N_IN legality check constant.
//  - One sub-module: mux_n1_comb (pure combinational N:1 select + range check -> word, err).
//  - Top holds state register, head and skid registers, output assigns.
// TESTING
//  - Reset: assert RST mid-stream with state FULL -> OUT_VALID=0, IN_READY=1, OUT=0 same cycle.
//  - Streaming: N_IN=4, IN0..3=0x11,0x22,0x33,0x44, SEL=0,1,2,3 back-to-back, OUT_READY=1
//    -> OUT=0x11,0x22,0x33,0x44 on 4 consecutive cycles, 1-cycle latency, IN_READY stays 1.
//  - Stall: OUT_READY=0 for 5 cycles while streaming -> FULL after 2 accepts, IN_READY=0,
//    OUT held; release -> remaining words exit in order, none lost or repeated.
//  - Out-of-range: N_IN=5 (SEL_W=3), SEL=6 -> OUT=0, SEL_ERR=1, OUT_SEL=6; next SEL=4 -> SEL_ERR=0.
//  - Flush: state FULL, FLUSH=1 with IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, new word dropped.
//  - Random: random IN_VALID/OUT_READY/SEL for 10k cycles vs. scoreboard model -> exact order match.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and parameter-legality helpers for the N:1 pipelined select.
package mux_pkg;

  // Occupancy of the head/skid register pair.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 16;

  function automatic bit n_in_legal(input int n);
    return (n >= N_IN_MIN) && (n <= N_IN_MAX);
  endfunction

endpackage

// File: rtl/mux_n1_comb.sv
// Pure combinational N:1 select with range check.
// A select value with no matching input yields a zero word and err=1.
module mux_n1_comb #(
  parameter int size  = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN*size-1:0] words,
  input  logic [SEL_W-1:0]     sel,
  output logic [size-1:0]      word,
  output logic                 err
);

  // Scan all inputs; exactly one matches an in-range select, none match otherwise.
  always_comb begin
    word = '0;
    err  = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        word = words[k*size +: size];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_n1_pipe.sv
// N:1 datapath select fused with a flow-controlled pipeline register.
// A head register drives the outputs; a single skid register absorbs the
// word accepted in the cycle a stall appears, so IN_READY comes straight
// from the state register and full throughput is kept.
//
//  state | meaning
//  EMPTY | no word held, OUT_VALID=0
//  ONE   | head valid, skid free
//  FULL  | head and skid valid, IN_READY=0
module mux_n1_pipe
  import mux_pkg::*;
#(
  parameter int size  = 32,
  parameter int N_IN  = 4,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_IN*size-1:0] IN,
  input  logic [SEL_W-1:0]     SEL,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic                 FLUSH,
  output logic [size-1:0]      OUT,
  output logic [SEL_W-1:0]     OUT_SEL,
  output logic                 SEL_ERR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY
);

  if (!n_in_legal(N_IN)) begin : g_bad_n_in
    $error("mux_n1_pipe: N_IN out of range 2..16");
  end

  skid_state_t        state;
  logic [size-1:0]    head_word;
  logic [SEL_W-1:0]   head_sel;
  logic               head_err;
  logic [size-1:0]    skid_word;
  logic [SEL_W-1:0]   skid_sel;
  logic               skid_err;

  logic [size-1:0]    new_word;
  logic               new_err;
  logic               accept;
  logic               drain;

  mux_n1_comb #(
    .size  (size),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_sel (
    .words (IN),
    .sel   (SEL),
    .word  (new_word),
    .err   (new_err)
  );

  // Handshake qualifiers; ready/valid are pure state decodes, no input feeds them.
  always_comb begin
    IN_READY  = (state != FULL);
    OUT_VALID = (state != EMPTY);
    accept    = IN_VALID & IN_READY;
    drain     = OUT_VALID & OUT_READY;
  end

  assign OUT     = head_word;
  assign OUT_SEL = head_sel;
  assign SEL_ERR = head_err;

  // Occupancy FSM with head/skid loads; flush empties the pair but leaves data in place.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      head_word <= '0;
      head_sel  <= '0;
      head_err  <= 1'b0;
      skid_word <= '0;
      skid_sel  <= '0;
      skid_err  <= 1'b0;
    end else if (FLUSH) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            head_word <= new_word;
            head_sel  <= SEL;
            head_err  <= new_err;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_word <= new_word;
            head_sel  <= SEL;
            head_err  <= new_err;
          end else if (accept) begin
            skid_word <= new_word;
            skid_sel  <= SEL;
            skid_err  <= new_err;
            state     <= FULL;
          end else if (drain) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            head_word <= skid_word;
            head_sel  <= skid_sel;
            head_err  <= skid_err;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_n1_pipe.sv
// Bench for mux_n1_pipe: an N_IN=4 and an N_IN=5 instance share the
// handshake controls; each has a queue model (at most two words in flight)
// checked every cycle, plus literal expectations on directed sequences.
module tb_mux_n1_pipe;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  s;
    logic        e;
  } word_t;

  logic         CLK;
  logic         RST;
  logic         FLUSH;
  logic         IN_VALID;
  logic         OUT_READY;

  logic [127:0] in4;
  logic [1:0]   sel4;
  logic [31:0]  out4;
  logic [1:0]   osel4;
  logic         err4, ov4, ir4;

  logic [159:0] in5;
  logic [2:0]   sel5;
  logic [31:0]  out5;
  logic [2:0]   osel5;
  logic         err5, ov5, ir5;

  int n_vec = 0;
  int n_err = 0;

  word_t q4[$];
  word_t q5[$];

  mux_n1_pipe #(.size(32), .N_IN(4)) dut4 (
    .CLK(CLK), .RST(RST), .IN(in4), .SEL(sel4), .IN_VALID(IN_VALID),
    .IN_READY(ir4), .FLUSH(FLUSH), .OUT(out4), .OUT_SEL(osel4),
    .SEL_ERR(err4), .OUT_VALID(ov4), .OUT_READY(OUT_READY)
  );

  mux_n1_pipe #(.size(32), .N_IN(5)) dut5 (
    .CLK(CLK), .RST(RST), .IN(in5), .SEL(sel5), .IN_VALID(IN_VALID),
    .IN_READY(ir5), .FLUSH(FLUSH), .OUT(out5), .OUT_SEL(osel5),
    .SEL_ERR(err5), .OUT_VALID(ov5), .OUT_READY(OUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t exp_word(input int n, input logic [159:0] bus, input int sel);
    word_t w;
    w.s = 3'(sel);
    if (sel < n) begin
      w.d = bus[sel*32 +: 32];
      w.e = 1'b0;
    end else begin
      w.d = 32'h0;
      w.e = 1'b1;
    end
    return w;
  endfunction

  // Reference: a queue of at most two words; accept when fewer than two are held.
  bit acc4, drn4, acc5, drn5;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      q4.delete();
      q5.delete();
    end else begin
      acc4 = IN_VALID && (q4.size() < 2);
      drn4 = OUT_READY && (q4.size() > 0);
      acc5 = IN_VALID && (q5.size() < 2);
      drn5 = OUT_READY && (q5.size() > 0);
      if (FLUSH) begin
        q4.delete();
        q5.delete();
      end else begin
        if (drn4) void'(q4.pop_front());
        if (acc4) q4.push_back(exp_word(4, {32'h0, in4}, int'(sel4)));
        if (drn5) void'(q5.pop_front());
        if (acc5) q5.push_back(exp_word(5, in5, int'(sel5)));
      end
    end
  end

  // Every cycle: outputs must equal the head of the model queue.
  always @(negedge CLK) begin
    if (!RST) begin
      check("d4_valid", 64'(ov4), 64'(q4.size() > 0));
      check("d4_ready", 64'(ir4), 64'(q4.size() < 2));
      if (q4.size() > 0) begin
        check("d4_out", 64'(out4), 64'(q4[0].d));
        check("d4_sel", 64'(osel4), 64'(q4[0].s));
        check("d4_err", 64'(err4), 64'(q4[0].e));
      end
      check("d5_valid", 64'(ov5), 64'(q5.size() > 0));
      check("d5_ready", 64'(ir5), 64'(q5.size() < 2));
      if (q5.size() > 0) begin
        check("d5_out", 64'(out5), 64'(q5[0].d));
        check("d5_sel", 64'(osel5), 64'(q5[0].s));
        check("d5_err", 64'(err5), 64'(q5[0].e));
      end
    end
  end

  initial begin
    RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    sel4 = 2'd0; sel5 = 3'd0;
    in4 = {32'h44, 32'h33, 32'h22, 32'h11};
    in5 = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    #1 RST = 1'b1;
    #2;
    check("rst_valid", 64'(ov4), 64'd0);
    check("rst_ready", 64'(ir4), 64'd1);
    check("rst_out", 64'(out4), 64'd0);
    check("rst_sel", 64'(osel4), 64'd0);
    check("rst_err", 64'(err4), 64'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // back-to-back stream, one-cycle latency
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (k > 0) check("stream_out", 64'(out4), 64'(32'h11 * (k)));
      check("stream_ready", 64'(ir4), 64'd1);
      IN_VALID = 1'b1;
      sel4 = 2'(k);
    end
    @(negedge CLK);
    check("stream_out", 64'(out4), 64'h44);
    IN_VALID = 1'b0;

    // five-cycle stall while streaming
    @(negedge CLK);
    check("drained", 64'(ov4), 64'd0);
    OUT_READY = 1'b0; IN_VALID = 1'b1; sel4 = 2'd1;
    @(negedge CLK);
    check("stall_head", 64'(out4), 64'h22);
    check("stall_ready1", 64'(ir4), 64'd1);
    sel4 = 2'd2;
    repeat (4) begin
      @(negedge CLK);
      check("stall_hold", 64'(out4), 64'h22);
      check("stall_full", 64'(ir4), 64'd0);
      sel4 = 2'd3;
    end
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("release_skid", 64'(out4), 64'h33);
    check("release_ready", 64'(ir4), 64'd1);
    @(negedge CLK);
    check("release_last", 64'(out4), 64'h44);
    IN_VALID = 1'b0;
    @(negedge CLK);
    check("release_empty", 64'(ov4), 64'd0);

    // flush from FULL with an offered word, then flush beating accept+drain
    OUT_READY = 1'b0; IN_VALID = 1'b1; sel4 = 2'd0;
    @(negedge CLK);
    sel4 = 2'd1;
    @(negedge CLK);
    check("pre_flush_full", 64'(ir4), 64'd0);
    check("pre_flush_head", 64'(out4), 64'h11);
    FLUSH = 1'b1; sel4 = 2'd2;
    @(negedge CLK);
    check("flush_valid", 64'(ov4), 64'd0);
    check("flush_ready", 64'(ir4), 64'd1);
    FLUSH = 1'b0; sel4 = 2'd3; OUT_READY = 1'b1;
    @(negedge CLK);
    check("post_flush_word", 64'(out4), 64'h44);
    FLUSH = 1'b1; sel4 = 2'd0;
    @(negedge CLK);
    check("flush_one", 64'(ov4), 64'd0);
    FLUSH = 1'b0; IN_VALID = 1'b0;

    // out-of-range select on the 5-input instance
    @(negedge CLK);
    IN_VALID = 1'b1; sel5 = 3'd6;
    @(negedge CLK);
    check("oor_out", 64'(out5), 64'd0);
    check("oor_err", 64'(err5), 64'd1);
    check("oor_sel", 64'(osel5), 64'd6);
    sel5 = 3'd4;
    @(negedge CLK);
    check("inr_out", 64'(out5), 64'h55);
    check("inr_err", 64'(err5), 64'd0);
    check("inr_sel", 64'(osel5), 64'd4);
    IN_VALID = 1'b0; sel5 = 3'd0;

    // asynchronous reset while FULL
    @(negedge CLK);
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_pre_full", 64'(ir4), 64'd0);
    RST = 1'b1;
    #1;
    check("arst_valid", 64'(ov4), 64'd0);
    check("arst_ready", 64'(ir4), 64'd1);
    check("arst_out", 64'(out4), 64'd0);
    check("arst_valid5", 64'(ov5), 64'd0);
    @(negedge CLK);
    RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;

    // randomized traffic against the queue model
    for (int c = 0; c < 10000; c++) begin
      @(negedge CLK);
      RST       = ($urandom_range(0, 1999) == 0);
      FLUSH     = ($urandom_range(0, 39) == 0);
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = (c % 200 < 20) ? 1'b0 : ($urandom_range(0, 3) != 0);
      sel4      = 2'($urandom_range(0, 3));
      sel5      = 3'($urandom_range(0, 7));
      in4       = {$urandom, $urandom, $urandom, $urandom};
      in5       = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
    @(negedge CLK);
    RST = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b1;
    repeat (4) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
